// File: rtl/mlp_pkg.sv
// Shared MLP types: weight word, loader state and regfile depths.
// Imported by the weight loader and its storage array.
package mlp_pkg;

  localparam int WEIGHT_W = 16;

  typedef logic [WEIGHT_W-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } wl_state_e;

  localparam int W1_DEPTH  = 18;
  localparam int W1_ADDR_W = 5;

  function automatic int addr_bits(input int depth);
    int n;
    n = 1;
    while ((1 << n) < depth) n++;
    return n;
  endfunction

endpackage

// File: rtl/wl_storage.sv
// Weight array: one sync write port, async clear,
// one combinational read port returning 0 out of range.
module wl_storage
  import mlp_pkg::*;
#(
  parameter int DATA_W = WEIGHT_W,
  parameter int DEPTH  = W1_DEPTH,
  parameter int ADDR_W = W1_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic wa_ok;
  logic ra_ok;

  assign wa_ok = {1'b0, wa} < DEPTH_C;
  assign ra_ok = {1'b0, ra} < DEPTH_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && wa_ok) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd = '0;
    if (ra_ok) rd = mem[ra];
  end

endmodule

// File: rtl/weight_loader_rf.sv
// Writable weight regfile fed by a valid/ready load stream,
// with progress counter and running checksum of the load.
module weight_loader_rf
  import mlp_pkg::*;
#(
  parameter int DATA_W = WEIGHT_W,
  parameter int DEPTH  = W1_DEPTH,
  parameter int ADDR_W = W1_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(DEPTH - 1);

  wl_state_e state;
  wl_state_e state_nx;

  logic hs;

  assign s_ready = (state == LOAD) && !start;
  assign hs      = s_valid && s_ready;
  assign busy      = (state == LOAD);
  assign load_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (start)
          state_nx = LOAD;
        else if (hs && word_count == LAST_C)
          state_nx = DONE;
      end
      DONE: begin
        if (start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // start clears in every state; s_ready masks any same-cycle word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      checksum   <= '0;
    end else if (start) begin
      word_count <= '0;
      checksum   <= '0;
    end else if (hs) begin
      word_count <= word_count + 1'b1;
      checksum   <= checksum + s_data;
    end
  end

  wl_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (hs),
    .wa    (word_count[ADDR_W-1:0]),
    .wd    (s_data),
    .ra    (ra),
    .rd    (rd)
  );

endmodule

// File: tb/tb_weight_loader_rf.sv
// Randomized self-checking bench for weight_loader_rf
// against a word-level model of the load protocol.
module tb_weight_loader_rf;

  localparam int DEPTH = 18;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        busy;
  logic        load_done;
  logic [5:0]  word_count;
  logic [15:0] checksum;
  logic [4:0]  ra;
  logic [15:0] rd;

  weight_loader_rf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .busy       (busy),
    .load_done  (load_done),
    .word_count (word_count),
    .checksum   (checksum),
    .ra         (ra),
    .rd         (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int errors;
  int rdy_cnt;

  // model: phase 0 idle, 1 loading, 2 complete
  int          mphase;
  int          mcnt;
  logic [15:0] msum;
  logic [15:0] mmem [DEPTH];

  function automatic logic [15:0] mread(input int a);
    if (a < DEPTH) return mmem[a];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    mphase = 0;
    mcnt   = 0;
    msum   = 16'h0000;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 16'h0000;
  endtask

  task automatic check_status(input string tag);
    vectors++;
    if (busy !== (mphase == 1) || load_done !== (mphase == 2)) begin
      errors++;
      $display("FAIL %s status: busy=%b done=%b want busy=%b done=%b",
               tag, busy, load_done, mphase == 1, mphase == 2);
    end
    vectors++;
    if (word_count !== 6'(mcnt)) begin
      errors++;
      $display("FAIL %s word_count: got %0d want %0d",
               tag, word_count, mcnt);
    end
    vectors++;
    if (checksum !== msum) begin
      errors++;
      $display("FAIL %s checksum: got %h want %h", tag, checksum, msum);
    end
  endtask

  // one clock cycle of stimulus; starts and ends 1 time unit after posedge
  task automatic step(input logic st, input logic v, input logic [15:0] d);
    logic exp_rdy;
    int   a;
    start   = st;
    s_valid = v;
    s_data  = d;
    a  = int'($urandom_range(0, 31));
    ra = 5'(a);
    #1;
    exp_rdy = (mphase == 1) && !st;
    vectors++;
    if (s_ready !== exp_rdy) begin
      errors++;
      $display("FAIL step s_ready: got %b want %b", s_ready, exp_rdy);
    end
    vectors++;
    if (rd !== mread(a)) begin
      errors++;
      $display("FAIL step rd[%0d]: got %h want %h", a, rd, mread(a));
    end
    if (s_ready) rdy_cnt++;
    @(posedge clk);
    if (st) begin
      mphase = 1;
      mcnt   = 0;
      msum   = 16'h0000;
    end else if (exp_rdy && v) begin
      mmem[mcnt] = d;
      mcnt++;
      msum = msum + d;
      if (mcnt == DEPTH) mphase = 2;
    end
    #1;
    check_status("step");
  endtask

  task automatic check_mem(input string tag);
    start   = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i);
      #1;
      vectors++;
      if (rd !== mread(i)) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h want %h", tag, i, rd, mread(i));
      end
    end
    if (rst_n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    ra      = 5'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    ra      = 5'd0;
    model_reset();
    #2;
    vectors++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset s_ready: got %b want 0", s_ready);
    end
    check_status("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_mem("reset");
  endtask

  task automatic test_full_load();
    step(1'b1, 1'b0, 16'h0000);
    rdy_cnt = 0;
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 16'(i));
    step(1'b0, 1'b0, 16'h0000);
    vectors++;
    if (rdy_cnt != DEPTH) begin
      errors++;
      $display("FAIL full ready_cycles: got %0d want %0d", rdy_cnt, DEPTH);
    end
    vectors++;
    if (checksum !== 16'h00AB || word_count !== 6'd18 || !load_done) begin
      errors++;
      $display("FAIL full final: sum=%h cnt=%0d done=%b want 00ab 18 1",
               checksum, word_count, load_done);
    end
    check_mem("full");
  endtask

  task automatic test_backpressure();
    int i;
    int k;
    step(1'b1, 1'b0, 16'h0000);
    i = 1;
    k = 0;
    while (i <= DEPTH && k < 200) begin
      if (k % 3 == 0) begin
        step(1'b0, 1'b1, 16'(i));
        i++;
      end else begin
        step(1'b0, 1'b0, 16'($urandom));
      end
      k++;
    end
    vectors++;
    if (i <= DEPTH) begin
      errors++;
      $display("FAIL gaps budget: got %0d words want %0d", i - 1, DEPTH);
    end
    vectors++;
    if (checksum !== 16'h00AB) begin
      errors++;
      $display("FAIL gaps checksum: got %h want 00ab", checksum);
    end
    check_mem("gaps");
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 16'hF000);
    vectors++;
    if (checksum !== 16'hE000) begin
      errors++;
      $display("FAIL wrap checksum: got %h want e000", checksum);
    end
    check_mem("wrap");
  endtask

  task automatic test_restart();
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'hAAAA);
    step(1'b1, 1'b1, 16'h5555);
    vectors++;
    if (word_count !== 6'd0 || !busy) begin
      errors++;
      $display("FAIL restart clear: cnt=%0d busy=%b want 0 1",
               word_count, busy);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 16'h1111);
    vectors++;
    if (checksum !== 16'h3332) begin
      errors++;
      $display("FAIL restart checksum: got %h want 3332", checksum);
    end
    check_mem("restart");
  endtask

  task automatic test_ignore();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hDEAD);
    check_mem("idle_ignore");
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 16'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hDEAD);
    vectors++;
    if (word_count !== 6'd18) begin
      errors++;
      $display("FAIL done_ignore cnt: got %0d want 18", word_count);
    end
    check_mem("done_ignore");
    step(1'b1, 1'b0, 16'h0000);
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'($urandom));
    s_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL async s_ready: got %b want 0", s_ready);
    end
    check_status("async");
    check_mem("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      logic st;
      st = ($urandom_range(0, 39) == 0) || (mphase != 1 && $urandom_range(0, 3) == 0);
      step(st, 1'($urandom_range(0, 2) != 0), 16'($urandom));
    end
    check_mem("random");
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rdy_cnt = 0;
    test_reset();
    test_full_load();
    test_backpressure();
    test_wrap();
    test_restart();
    test_ignore();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
